// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared types and defaults for the fetch-to-decode instruction queue
package inst_queue_pkg;

    // Mirrors FS_TO_DS_BUS_WD from the CPU header; the queue never looks inside a packet.
    localparam int FS_TO_DS_BUS_WD  = 109;
    localparam int IQ_DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IQ_HOLD = 2'b00,
        IQ_POP  = 2'b01,
        IQ_PUSH = 2'b10,
        IQ_BOTH = 2'b11
    } iq_op_e;

    function automatic iq_op_e iq_op(input logic push, input logic pop);
        return iq_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/inst_queue_iq_regfile.sv
// rtl/inst_queue_iq_regfile.sv - DEPTH x WIDTH packet storage, one write port, one async read port
module iq_regfile #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 109,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Entries are deliberately not reset; validity is tracked by the occupancy count.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - in-order decoupling queue between fetch and decode with flush
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEFAULT_DEPTH,
    parameter int BUS_WD = FS_TO_DS_BUS_WD
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     fs_to_iq_valid,
    input  logic [BUS_WD-1:0]        fs_to_iq_bus,
    output logic                     iq_allowin,
    output logic                     iq_to_ds_valid,
    output logic [BUS_WD-1:0]        iq_to_ds_bus,
    input  logic                     ds_allowin,
    output logic [$clog2(DEPTH):0]   iq_count
);

    localparam int IQ_PTR_WD = $clog2(DEPTH);
    localparam int CNT_WD    = IQ_PTR_WD + 1;
    localparam logic [CNT_WD-1:0]    FULL_CNT = CNT_WD'(DEPTH);
    localparam logic [IQ_PTR_WD-1:0] PTR_ONE  = IQ_PTR_WD'(1);
    localparam logic [CNT_WD-1:0]    CNT_ONE  = CNT_WD'(1);

    logic                 resetn_q;
    logic [IQ_PTR_WD-1:0] wr_ptr;
    logic [IQ_PTR_WD-1:0] rd_ptr;
    logic [CNT_WD-1:0]    count;
    logic                 push;
    logic                 pop;
    logic                 wr_en;
    iq_op_e               op;

    // Holds allowin low for the first cycle after reset release.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resetn_q <= 1'b0;
        end else begin
            resetn_q <= 1'b1;
        end
    end

    // Only registered state feeds allowin, so decode stalls never reach fetch combinationally.
    assign iq_allowin     = resetn_q && (count != FULL_CNT);
    assign iq_to_ds_valid = (count != '0);
    assign push           = fs_to_iq_valid && iq_allowin;
    assign pop            = iq_to_ds_valid && ds_allowin;
    assign op             = iq_op(push, pop);
    assign wr_en          = push && !flush;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (op)
                IQ_PUSH: count <= count + CNT_ONE;
                IQ_POP:  count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    iq_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (BUS_WD),
        .AW    (IQ_PTR_WD)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (fs_to_iq_bus),
        .raddr (rd_ptr),
        .rdata (iq_to_ds_bus)
    );

    assign iq_count = count;

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - randomized and directed self-checking bench for inst_queue
module tb_inst_queue;

    localparam int DEPTH  = 4;
    localparam int BUS_WD = 109;
    localparam int CNT_WD = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic              fs_to_iq_valid;
    logic [BUS_WD-1:0] fs_to_iq_bus;
    logic              iq_allowin;
    logic              iq_to_ds_valid;
    logic [BUS_WD-1:0] iq_to_ds_bus;
    logic              ds_allowin;
    logic [CNT_WD-1:0] iq_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [BUS_WD-1:0] m_q[$];
    bit                m_rq = 1'b0;

    inst_queue #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .fs_to_iq_valid (fs_to_iq_valid),
        .fs_to_iq_bus   (fs_to_iq_bus),
        .iq_allowin     (iq_allowin),
        .iq_to_ds_valid (iq_to_ds_valid),
        .iq_to_ds_bus   (iq_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .iq_count       (iq_count)
    );

    always #5 clk = ~clk;

    function automatic logic [BUS_WD-1:0] mk(input logic [31:0] pc);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return {r[BUS_WD-33:0], pc};
    endfunction

    function automatic bit exp_allowin();
        return m_rq && (m_q.size() != DEPTH);
    endfunction

    function automatic bit exp_valid();
        return m_q.size() != 0;
    endfunction

    function automatic logic [CNT_WD-1:0] exp_count();
        return CNT_WD'(m_q.size());
    endfunction

    // Drives one cycle of inputs, clocks, and advances the queue model.
    task automatic step(input bit rn, input bit fl, input bit fv,
                        input logic [BUS_WD-1:0] bus, input bit dsa);
        bit p;
        bit o;
        resetn = rn; flush = fl; fs_to_iq_valid = fv; fs_to_iq_bus = bus; ds_allowin = dsa;
        p = fv && exp_allowin();
        o = exp_valid() && dsa;
        @(posedge clk);
        if (!rn) begin
            m_q.delete(); m_rq = 1'b0;
        end else if (fl) begin
            m_q.delete(); m_rq = 1'b1;
        end else begin
            if (o) void'(m_q.pop_front());
            if (p) m_q.push_back(bus);
            m_rq = 1'b1;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && m_q.size() != 0; i++) step(1, 0, 0, '0, 1);
    endtask

    task automatic test_reset();
        step(0, 1, 1, mk(32'h1c00_0000), 1);
        step(0, 0, 1, mk(32'h1c00_0004), 1);
        n_checks++; if (iq_allowin !== 1'b0) begin n_errors++; $display("FAIL reset_allowin: got %b expected 0", iq_allowin); end
        n_checks++; if (iq_to_ds_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", iq_to_ds_valid); end
        n_checks++; if (iq_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", iq_count); end
        resetn = 1'b1; fs_to_iq_valid = 1'b0; flush = 1'b0; ds_allowin = 1'b0;
        #1;
        n_checks++; if (iq_allowin !== 1'b0) begin n_errors++; $display("FAIL release_cycle1_allowin: got %b expected 0", iq_allowin); end
        step(1, 0, 0, '0, 0);
        n_checks++; if (iq_allowin !== 1'b1) begin n_errors++; $display("FAIL release_cycle2_allowin: got %b expected 1", iq_allowin); end
    endtask

    task automatic test_single_push();
        step(1, 0, 1, mk(32'h1c00_0000), 0);
        n_checks++; if (iq_to_ds_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b expected 1", iq_to_ds_valid); end
        n_checks++; if (iq_to_ds_bus[31:0] !== 32'h1c00_0000) begin n_errors++; $display("FAIL single_pc: got %h expected 1c000000", iq_to_ds_bus[31:0]); end
        n_checks++; if (iq_to_ds_bus !== m_q[0]) begin n_errors++; $display("FAIL single_bus: got %h expected %h", iq_to_ds_bus, m_q[0]); end
        n_checks++; if (iq_count !== 3'd1) begin n_errors++; $display("FAIL single_count: got %0d expected 1", iq_count); end
        drain();
        n_checks++; if (iq_to_ds_valid !== 1'b0) begin n_errors++; $display("FAIL single_drained: got %b expected 0", iq_to_ds_valid); end
    endtask

    task automatic test_fill_drain();
        for (int k = 0; k < DEPTH; k++) step(1, 0, 1, mk(32'h1c00_0000 + 32'(4 * k)), 0);
        n_checks++; if (iq_count !== exp_count() || iq_count !== 3'd4) begin n_errors++; $display("FAIL fill_count: got %0d expected 4", iq_count); end
        n_checks++; if (iq_allowin !== 1'b0) begin n_errors++; $display("FAIL fill_allowin: got %b expected 0", iq_allowin); end
        step(1, 0, 1, mk(32'h1c00_0010), 0);
        n_checks++; if (iq_count !== 3'd4) begin n_errors++; $display("FAIL fill_held_count: got %0d expected 4", iq_count); end
        for (int k = 0; k < DEPTH; k++) begin
            n_checks++;
            if (iq_to_ds_valid !== 1'b1 || iq_to_ds_bus[31:0] !== 32'h1c00_0000 + 32'(4 * k) || iq_to_ds_bus !== m_q[0]) begin
                n_errors++; $display("FAIL drain_order[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, iq_to_ds_valid, iq_to_ds_bus[31:0], 32'h1c00_0000 + 32'(4 * k));
            end
            step(1, 0, 0, '0, 1);
        end
        n_checks++; if (iq_to_ds_valid !== 1'b0 || iq_count !== 3'd0) begin n_errors++; $display("FAIL drain_empty: got v=%b cnt=%0d expected v=0 cnt=0", iq_to_ds_valid, iq_count); end
    endtask

    task automatic test_stream_wrap();
        step(1, 0, 1, mk(32'h1c00_0000), 1);
        for (int k = 1; k < 10; k++) begin
            n_checks++;
            if (iq_to_ds_bus[31:0] !== 32'h1c00_0000 + 32'(4 * (k - 1)) || iq_to_ds_bus !== m_q[0]) begin
                n_errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, iq_to_ds_bus[31:0], 32'h1c00_0000 + 32'(4 * (k - 1)));
            end
            step(1, 0, 1, mk(32'h1c00_0000 + 32'(4 * k)), 1);
            n_checks++; if (iq_count !== 3'd1) begin n_errors++; $display("FAIL stream_count[%0d]: got %0d expected 1", k, iq_count); end
        end
        n_checks++; if (iq_to_ds_bus[31:0] !== 32'h1c00_0024) begin n_errors++; $display("FAIL stream_last: got %h expected 1c000024", iq_to_ds_bus[31:0]); end
        drain();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) step(1, 0, 1, mk(32'h1c00_0100 + 32'(4 * k)), 0);
        n_checks++; if (iq_count !== 3'd3) begin n_errors++; $display("FAIL flush_pre_count: got %0d expected 3", iq_count); end
        step(1, 1, 1, mk(32'h1c00_0abc), 1);
        n_checks++; if (iq_count !== 3'd0 || iq_to_ds_valid !== 1'b0) begin n_errors++; $display("FAIL flush_clear: got cnt=%0d v=%b expected cnt=0 v=0", iq_count, iq_to_ds_valid); end
        step(1, 0, 1, mk(32'h1c00_8000), 0);
        n_checks++; if (iq_to_ds_bus[31:0] !== 32'h1c00_8000 || iq_to_ds_bus !== m_q[0] || iq_count !== 3'd1) begin
            n_errors++; $display("FAIL flush_next: got pc=%h cnt=%0d expected pc=1c008000 cnt=1", iq_to_ds_bus[31:0], iq_count);
        end
        drain();
    endtask

    task automatic test_full_pop();
        for (int k = 0; k < DEPTH; k++) step(1, 0, 1, mk(32'h1c00_0200 + 32'(4 * k)), 0);
        n_checks++; if (iq_allowin !== 1'b0) begin n_errors++; $display("FAIL fullpop_allowin_during: got %b expected 0", iq_allowin); end
        step(1, 0, 1, mk(32'h1c00_0f00), 1);
        n_checks++; if (iq_allowin !== 1'b1 || iq_count !== 3'd3) begin n_errors++; $display("FAIL fullpop_after: got a=%b cnt=%0d expected a=1 cnt=3", iq_allowin, iq_count); end
        n_checks++; if (iq_to_ds_bus[31:0] !== 32'h1c00_0204) begin n_errors++; $display("FAIL fullpop_head: got %h expected 1c000204", iq_to_ds_bus[31:0]); end
        drain();
    endtask

    task automatic test_reset_mid();
        step(1, 0, 1, mk(32'h1c00_0300), 0);
        step(1, 0, 1, mk(32'h1c00_0304), 0);
        step(0, 1, 1, mk(32'h1c00_0308), 1);
        n_checks++; if (iq_count !== 3'd0 || iq_to_ds_valid !== 1'b0 || iq_allowin !== 1'b0) begin
            n_errors++; $display("FAIL midreset: got cnt=%0d v=%b a=%b expected 0 0 0", iq_count, iq_to_ds_valid, iq_allowin);
        end
        step(1, 0, 1, mk(32'h1c00_030c), 0);
        n_checks++; if (iq_count !== 3'd0) begin n_errors++; $display("FAIL midreset_release_push: got %0d expected 0", iq_count); end
        step(1, 0, 0, '0, 0);
    endtask

    task automatic test_random();
        bit rn, fl, fv, dsa;
        for (int i = 0; i < 600; i++) begin
            n_checks++; if (iq_allowin !== exp_allowin()) begin n_errors++; $display("FAIL rand_allowin[%0d]: got %b expected %b", i, iq_allowin, exp_allowin()); end
            n_checks++; if (iq_to_ds_valid !== exp_valid()) begin n_errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, iq_to_ds_valid, exp_valid()); end
            n_checks++; if (iq_count !== exp_count()) begin n_errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, iq_count, exp_count()); end
            if (m_q.size() != 0) begin
                n_checks++; if (iq_to_ds_bus !== m_q[0]) begin n_errors++; $display("FAIL rand_bus[%0d]: got %h expected %h", i, iq_to_ds_bus, m_q[0]); end
            end
            rn  = ($urandom % 80) != 0;
            fl  = ($urandom % 24) == 0;
            fv  = ($urandom % 4) != 0;
            dsa = ((i / 60) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            step(rn, fl, fv, mk($urandom()), dsa);
        end
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; fs_to_iq_valid = 1'b0; fs_to_iq_bus = '0; ds_allowin = 1'b0;
        test_reset();
        test_single_push();
        test_fill_drain();
        test_stream_wrap();
        test_flush();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
